apb2_request_arbiter: RTL and testbench
=======================================

# apb2_request_arbiter

Shares one APB2 slave port (the FPGA test-shield register bank) among `NUM_REQ` internal requesters, such as the SPI command bridge and on-chip test sequencers. Each requester raises a simple valid/done request carrying address, direction and write data. The block grants one request at a time using round-robin priority. It drives the APB2 setup/access sequence and returns read data with a one-cycle completion pulse. The APB2 side has no PREADY, so every transfer has a fixed length.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, APB address width in bits (8..32).
- `NUM_REQ`, 2, number of requesters (1..4).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NUM_REQ  per-requester request; bit i = requester i.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*8  flattened write data; requester i at [i*8 +: 8].
- `req_done`  out  NUM_REQ  one-cycle completion pulse, one-hot.
- `req_rdata`  out  8  read data of the last completed transfer.
- `PADDR`  out  ADDR_WIDTH  APB address.
- `PSEL`  out  1  APB select.
- `PENABLE`  out  1  APB enable.
- `PWRITE`  out  1  APB direction.
- `PWDATA`  out  8  APB write data.
- `PRDATA`  in  8  APB read data.

## Operation
- All outputs are registered.
- Reset values: `PADDR`=0, `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PWDATA`=0, `req_done`=0, `req_rdata`=0, state=IDLE, `last_grant`=NUM_REQ-1. With this `last_grant`, requester 0 wins first after reset.
- State machine has four states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any `req_valid` bit is set, pick a winner.
  - Search order is `last_grant`+1, +2, … modulo NUM_REQ; the first set bit wins.
  - Latch `winner`. Load `PADDR`, `PWRITE` and `PWDATA` from that requester's fields.
  - For a read, `PWDATA` is loaded with 0.
  - Set `PSEL`=1 and go to SETUP.
  - If no request is pending, stay in IDLE.
- SETUP: set `PENABLE`=1 and go to ACCESS.
- ACCESS: sample `PRDATA` at the closing edge.
  - Clear `PSEL` and `PENABLE`.
  - Set `req_rdata` to `PRDATA` for a read, or 0 for a write.
  - Set `req_done[winner]`=1, set `last_grant`=`winner`, and go to DONE.
- DONE: clear `req_done` and go to IDLE. No arbitration happens in DONE.
  - This gives the requester one cycle to drop or update `req_valid` after seeing `req_done`.
- Requester rules:
  - Hold `req_valid`, `req_write`, `req_addr` and `req_wdata` stable from assertion until the cycle `req_done[i]` is high.
  - In that cycle, either deassert `req_valid` or present the next request.
  - Request fields are sampled only in IDLE. Later changes do not affect a transfer in progress.
- Early drop of `req_valid` during SETUP or ACCESS is tolerated. The transfer completes and `req_done` still pulses.
- `PADDR`, `PWRITE` and `PWDATA` hold their last values while idle. Only `PSEL`/`PENABLE` return to 0.
- `req_rdata` holds until the next completion.
- With NUM_REQ=1 the block degenerates to a fixed 4-cycle sequencer.

## Timing
- Cycle numbering, for `req_valid[i]` first seen high in IDLE at cycle 0:
  - Cycle 1 (SETUP): `PSEL`=1, `PENABLE`=0.
  - Cycle 2 (ACCESS): `PSEL`=1, `PENABLE`=1; `PRDATA` sampled at end of cycle.
  - Cycle 3 (DONE): `PSEL`=0, `req_done[i]`=1, `req_rdata` valid.
  - Cycle 4 (IDLE): next arbitration.
- Latency from request to `req_done` is 3 cycles.
- Throughput is one transfer per 4 cycles, whether back-to-back or alternating between requesters.
- Simultaneous requests are resolved by the round-robin pointer only. There is no fixed priority once any transfer has completed.
- Reset asserted in any state takes effect at the next edge with the reset values above.
  - An aborted transfer produces no `req_done` pulse.
  - `last_grant` returns to NUM_REQ-1.

## Test plan
- **Single read.** Requester 0 reads 0x12; slave returns 0xA5 → `PSEL` high cycles 1-2, `PENABLE` high cycle 2 only, `PWRITE`=0. Then `req_done`=01 in cycle 3 and `req_rdata`=0xA5.
- **Single write.** Requester 1 writes 0x3C to 0x40 → `PADDR`=0x40, `PWRITE`=1, `PWDATA`=0x3C during cycles 1-2. Then `req_done`=10 and `req_rdata`=0x00.
- **Simultaneous first requests after reset.** Both requesters assert in the same cycle → requester 0 is granted first, `req_done` pulses 01. Requester 1 completes 4 cycles later with `req_done`=10.
- **Continuous contention.** Both requesters hold `req_valid` for 8 transfers → grants alternate 0,1,0,1…; `req_done` pulses exactly every 4 cycles; no requester is starved.
- **Reset mid-access.** Assert `rst` during ACCESS → next cycle `PSEL`=`PENABLE`=0, no `req_done` pulse, `req_rdata`=0. A following request from requester 1 alone is still served correctly.
- **Early drop and held outputs.** Requester 0 drops `req_valid` during SETUP → transfer completes and `req_done` pulses. Afterwards `PADDR`/`PWDATA` hold their last values while `PSEL` stays 0.

Source files
------------

// File: rtl/apb2_request_arbiter.sv
// Round-robin arbiter that shares one APB2 slave port among NUM_REQ requesters.
// Every transfer is a fixed IDLE -> SETUP -> ACCESS -> DONE sequence (no PREADY).
module apb2_request_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_REQ    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]          req_wdata,
   output logic [NUM_REQ-1:0]            req_done,
   output logic [7:0]                    req_rdata,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic                          PSEL,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [7:0]                    PWDATA,
   input  logic [7:0]                    PRDATA
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       winner_q, winner_d;
   logic [IDX_W-1:0]       last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [7:0]             pwdata_q, pwdata_d;
   logic [NUM_REQ-1:0]     req_done_q, req_done_d;
   logic [7:0]             req_rdata_q, req_rdata_d;

   logic                   found;
   logic [IDX_W-1:0]       pick;

   // Search starts one past the last grant so the previous winner ranks lowest.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         logic [IDX_W-1:0] cand;
         cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      last_grant_d = last_grant_q;
      paddr_d      = paddr_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      req_done_d   = '0;
      req_rdata_d  = req_rdata_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               winner_d = pick;
               paddr_d  = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
               pwrite_d = req_write[pick];
               pwdata_d = req_write[pick] ? req_wdata[int'(pick)*8 +: 8] : 8'h00;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            psel_d               = 1'b0;
            penable_d            = 1'b0;
            req_rdata_d          = pwrite_q ? 8'h00 : PRDATA;
            req_done_d[winner_q] = 1'b1;
            last_grant_d         = winner_q;
            state_d              = DONE;
         end
         DONE: begin
            // Arbitration skipped here so the requester can react to req_done.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         winner_q     <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         paddr_q      <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         req_done_q   <= '0;
         req_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         last_grant_q <= last_grant_d;
         paddr_q      <= paddr_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         req_done_q   <= req_done_d;
         req_rdata_q  <= req_rdata_d;
      end
   end

   assign PADDR     = paddr_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign req_done  = req_done_q;
   assign req_rdata = req_rdata_q;

endmodule

// File: tb/tb_apb2_request_arbiter.sv
// Directed testbench for apb2_request_arbiter with two requesters and 8-bit addresses.
module tb_apb2_request_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_done;
   logic [7:0]  req_rdata;
   logic [7:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [7:0]  PWDATA;
   logic [7:0]  PRDATA;

   int checkCount;
   int errorCount;

   apb2_request_arbiter #(
      .ADDR_WIDTH(8),
      .NUM_REQ(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_done(req_done),
      .req_rdata(req_rdata),
      .PADDR(PADDR),
      .PSEL(PSEL),
      .PENABLE(PENABLE),
      .PWRITE(PWRITE),
      .PWDATA(PWDATA),
      .PRDATA(PRDATA)
   );

   // 100 MHz free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives all requester inputs in one go.
   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] write,
                                input logic [15:0] addr, input logic [15:0] wdata);
      req_valid = valid;
      req_write = write;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   // Moves to just after the next rising edge, where outputs are stable.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      rst = 1'b1;
      stepCycle();
      stepCycle();
      rst = 1'b0;
   endtask

   // Called in the IDLE arbitration cycle; walks SETUP, ACCESS and ends in DONE.
   task automatic expectTransfer(input string tag, input logic [1:0] expDone, input logic [7:0] expAddr,
                                 input logic expWrite, input logic [7:0] expWdata,
                                 input logic [7:0] expRdata, input logic dropInSetup);
      stepCycle();
      checkOutput({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
      checkOutput({tag, "_setup_penable"}, 32'(PENABLE), 32'd0);
      checkOutput({tag, "_setup_paddr"}, 32'(PADDR), 32'(expAddr));
      checkOutput({tag, "_setup_pwrite"}, 32'(PWRITE), 32'(expWrite));
      checkOutput({tag, "_setup_pwdata"}, 32'(PWDATA), 32'(expWdata));
      checkOutput({tag, "_setup_done"}, 32'(req_done), 32'd0);
      if (dropInSetup) begin
         applyStimulus(2'b00, 2'b00, 16'hFFFF, 16'hFFFF);
      end
      stepCycle();
      checkOutput({tag, "_access_psel"}, 32'(PSEL), 32'd1);
      checkOutput({tag, "_access_penable"}, 32'(PENABLE), 32'd1);
      checkOutput({tag, "_access_paddr"}, 32'(PADDR), 32'(expAddr));
      stepCycle();
      checkOutput({tag, "_done_pulse"}, 32'(req_done), 32'(expDone));
      checkOutput({tag, "_done_rdata"}, 32'(req_rdata), 32'(expRdata));
      checkOutput({tag, "_done_psel"}, 32'(PSEL), 32'd0);
      checkOutput({tag, "_done_penable"}, 32'(PENABLE), 32'd0);
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst        = 1'b1;
      PRDATA     = 8'h00;
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);

      // Reset values.
      doReset();
      checkOutput("rst_psel", 32'(PSEL), 32'd0);
      checkOutput("rst_penable", 32'(PENABLE), 32'd0);
      checkOutput("rst_paddr", 32'(PADDR), 32'd0);
      checkOutput("rst_pwrite", 32'(PWRITE), 32'd0);
      checkOutput("rst_pwdata", 32'(PWDATA), 32'd0);
      checkOutput("rst_done", 32'(req_done), 32'd0);
      checkOutput("rst_rdata", 32'(req_rdata), 32'd0);

      // Single read by requester 0.
      $display("[TB] single read");
      PRDATA = 8'hA5;
      applyStimulus(2'b01, 2'b00, 16'h0012, 16'h0000);
      expectTransfer("rd0", 2'b01, 8'h12, 1'b0, 8'h00, 8'hA5, 1'b0);
      applyStimulus(2'b00, 2'b00, 16'h0012, 16'h0000);
      stepCycle();
      checkOutput("rd0_after_done", 32'(req_done), 32'd0);

      // Single write by requester 1.
      $display("[TB] single write");
      applyStimulus(2'b10, 2'b10, 16'h4000, 16'h3C00);
      expectTransfer("wr1", 2'b10, 8'h40, 1'b1, 8'h3C, 8'h00, 1'b0);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      stepCycle();

      // Simultaneous first requests after reset, then sustained contention.
      $display("[TB] contention");
      doReset();
      PRDATA = 8'h5C;
      applyStimulus(2'b11, 2'b10, 16'h2120, 16'h7700);
      expectTransfer("sim0", 2'b01, 8'h20, 1'b0, 8'h00, 8'h5C, 1'b0);
      stepCycle();
      checkOutput("sim_gap_done", 32'(req_done), 32'd0);
      expectTransfer("sim1", 2'b10, 8'h21, 1'b1, 8'h77, 8'h00, 1'b0);
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         checkOutput("cont_gap_done", 32'(req_done), 32'd0);
         checkOutput("cont_gap_psel", 32'(PSEL), 32'd0);
         PRDATA = 8'(8'h30 + k);
         if (k % 2 == 0)
            expectTransfer("cont0", 2'b01, 8'h20, 1'b0, 8'h00, 8'(8'h30 + k), 1'b0);
         else
            expectTransfer("cont1", 2'b10, 8'h21, 1'b1, 8'h77, 8'h00, 1'b0);
      end
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      stepCycle();

      // Reset during ACCESS aborts without a completion pulse.
      $display("[TB] reset mid-access");
      PRDATA = 8'h99;
      applyStimulus(2'b01, 2'b00, 16'h0055, 16'h0000);
      stepCycle();
      stepCycle();
      checkOutput("abort_in_access", 32'(PENABLE), 32'd1);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      checkOutput("abort_psel", 32'(PSEL), 32'd0);
      checkOutput("abort_penable", 32'(PENABLE), 32'd0);
      checkOutput("abort_done", 32'(req_done), 32'd0);
      checkOutput("abort_rdata", 32'(req_rdata), 32'd0);
      stepCycle();
      checkOutput("abort_no_late_done", 32'(req_done), 32'd0);
      PRDATA = 8'h5A;
      applyStimulus(2'b10, 2'b00, 16'h6600, 16'h0000);
      expectTransfer("post_abort1", 2'b10, 8'h66, 1'b0, 8'h00, 8'h5A, 1'b0);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      stepCycle();

      // Early drop during SETUP; bus fields then hold while idle.
      $display("[TB] early drop");
      applyStimulus(2'b01, 2'b01, 16'h007E, 16'h00C3);
      expectTransfer("drop0", 2'b01, 8'h7E, 1'b1, 8'hC3, 8'h00, 1'b1);
      applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
      for (int k = 0; k < 3; k++) begin
         stepCycle();
         checkOutput("hold_psel", 32'(PSEL), 32'd0);
         checkOutput("hold_paddr", 32'(PADDR), 32'h7E);
         checkOutput("hold_pwdata", 32'(PWDATA), 32'hC3);
         checkOutput("hold_pwrite", 32'(PWRITE), 32'd1);
         checkOutput("hold_done", 32'(req_done), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
